mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter that lets the core's instruction-fetch port and data-memory port share one synchronous single-ported RAM. It sits between the core's `im_*`/`dm_*` interfaces and the memory macro. It grants at most one access per cycle, with data over instruction priority and a starvation guard for fetch. It returns read data one cycle after grant, routed to the requester that issued the read.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of requester ports.
- `DATA_W`, 32: data width.
- `MAX_I_WAIT`, 4: consecutive fetch-denied cycles before fetch gets priority. Legal range 1..15.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `im_req_i`  in  1  fetch request; held with `im_addr_i` stable until `im_gnt_o`.
- `im_addr_i`  in  ADDR_W  fetch byte address.
- `im_gnt_o`  out  1  fetch accepted this cycle.
- `im_rvalid_o`  out  1  fetch data valid.
- `im_rdata_o`  out  DATA_W  fetch data; 0 when `im_rvalid_o`=0.
- `dm_req_i`  in  1  data request; held with its payload stable until `dm_gnt_o`.
- `dm_we_i`  in  DATA_W/8  byte write enables; 0 means read.
- `dm_addr_i`  in  ADDR_W  data byte address.
- `dm_wdata_i`  in  DATA_W  store data.
- `dm_gnt_o`  out  1  data access accepted this cycle.
- `dm_rvalid_o`  out  1  load data valid.
- `dm_rdata_o`  out  DATA_W  load data; 0 when `dm_rvalid_o`=0.
- `mem_en_o`  out  1  memory access strobe.
- `mem_we_o`  out  DATA_W/8  memory byte write enables.
- `mem_addr_o`  out  ADDR_W-2  word address, equal to `addr[ADDR_W-1:2]`.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_rdata_i`  in  DATA_W  memory read data, valid the cycle after a read strobe.

## Operation
- **Grant (combinational):**
  - fetch wins if `im_req_i` && (!`dm_req_i` || `prio`==IM_PRIO).
  - Otherwise data wins if `dm_req_i`.
  - At most one grant per cycle.
  - During `rst_i`, both grants and `mem_en_o` are 0.
- **Memory drive:** `mem_*` carry the winner's payload. Fetch always reads (`mem_we_o`=0). With no winner, `mem_en_o`=0 and the other `mem_*` outputs are 0.
- **Starvation counter** `i_wait`, 4 bits:
  - increments when `im_req_i` && !`im_gnt_o`, saturating at `MAX_I_WAIT`;
  - clears when `im_gnt_o` or !`im_req_i`.
- **Priority FSM:**
  - DM_PRIO → IM_PRIO when the next value of `i_wait` equals `MAX_I_WAIT`.
  - IM_PRIO → DM_PRIO on `im_gnt_o`.
- **Response tracking:** register `resp_own` loads each cycle:
  - RESP_IM on fetch grant;
  - RESP_DM on a data grant with `dm_we_i`==0;
  - else RESP_NONE.
  
  `im_rvalid_o` = (`resp_own`==RESP_IM) and `dm_rvalid_o` = (`resp_own`==RESP_DM), each passing `mem_rdata_i`. Writes complete at grant and produce no rvalid.
- Back-to-back grants are allowed. A grant in cycle N and another in N+1 yield rvalids in N+1 and N+2 respectively.

## Timing
- **Reset values:** `i_wait`=0, `prio`=DM_PRIO, `resp_own`=RESP_NONE. Both rvalids are 0 and both rdata outputs are 0 in the cycle after `rst_i` is sampled high.
- **Read latency:** exactly 1 cycle from grant to rvalid.
- **Write latency:** 0 cycles; the memory commits on the grant edge.
- **Reset mid-read:** with a grant in cycle N and `rst_i` high at the end of N, no rvalid appears in N+1.
- **Continuous contention:** fetch is granted no later than `MAX_I_WAIT` cycles after its first denial, so the fetch:data ratio is 1:`MAX_I_WAIT`.
- **Request dropped while denied:** `i_wait` clears. A stale IM_PRIO grants nothing extra; it simply lets the next fetch request win.
- **Low address bits:** ignored. Misalignment is the requester's responsibility.

## Structure
- The shared package `proc_pkg` holds:
  - `typedef enum logic [1:0] {RESP_NONE, RESP_IM, RESP_DM} arb_resp_t`;
  - `typedef enum logic {DM_PRIO, IM_PRIO} arb_prio_t`;
  - constant `ARB_MAX_I_WAIT_DEFAULT` = 4.
- One natural sub-module, `arb_starve_cnt`: the saturating counter plus priority flop, with ports `clk_i`, `rst_i`, `req_i`, `gnt_i`, `prio_o`.
- The grant mux and response register stay flat in `mem_arbiter`.

## Test plan
- **Fetch read alone:**
  - Stimulus: `im_req_i`=1, `im_addr_i`=0x100; memory word 0x40 holds 0xDEADBEEF.
  - Response: `im_gnt_o`=1 and `mem_addr_o`=0x40 in the same cycle; next cycle `im_rvalid_o`=1, `im_rdata_o`=0xDEADBEEF, `dm_rvalid_o`=0.
- **Data write:**
  - Stimulus: `dm_we_i`=4'b0011, `dm_addr_i`=0x8, `dm_wdata_i`=0x1234ABCD.
  - Response: `dm_gnt_o`=1, `mem_we_o`=4'b0011, `mem_addr_o`=2; no rvalid the following cycle.
- **Sustained contention, `MAX_I_WAIT`=4:**
  - Stimulus: both ports request reads every cycle.
  - Response: grant sequence D,D,D,D,I repeating; each rvalid matches its owner with 1-cycle lag.
- **Back-to-back reads:**
  - Stimulus: data read to 0x10, then fetch read to 0x20 in consecutive cycles.
  - Response: `dm_rvalid_o` in N+1 with word 4 data, then `im_rvalid_o` in N+2 with word 8 data; never both in one cycle.
- **Reset mid-read:**
  - Stimulus: fetch granted with `rst_i`=1 in the same cycle.
  - Response: no rvalid next cycle; `i_wait`=0, `prio`=DM_PRIO; the first post-reset contention grants data.
- **Dropped request:**
  - Stimulus: fetch denied 3 cycles, then `im_req_i`=0 for 1 cycle, then both request again.
  - Response: `i_wait` restarts from 0, so data gets 4 more grants before fetch.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared types and constants for the core's memory-side blocks.
//   arb_resp_t : which requester owns the read data returning next cycle
//   arb_prio_t : current arbitration priority between fetch and data ports
//   ARB_MAX_I_WAIT_DEFAULT : default fetch starvation limit for mem_arbiter
// -----------------------------------------------------------------------------
package proc_pkg;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IM,
        RESP_DM
    } arb_resp_t;

    typedef enum logic {
        DM_PRIO,
        IM_PRIO
    } arb_prio_t;

    localparam int ARB_MAX_I_WAIT_DEFAULT = 4;

    // Width of the fetch starvation counter; limits MAX_I_WAIT to 1..15.
    localparam int ARB_I_WAIT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// arb_starve_cnt
// Fetch starvation guard for mem_arbiter: counts consecutive cycles in which
// fetch requests but is denied, and raises fetch priority once the count
// reaches MAX_I_WAIT. Priority drops back to data as soon as fetch is granted.
//
// Ports
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset
//   req_i   in   fetch request
//   gnt_i   in   fetch grant
//   prio_o  out  current priority (arb_prio_t encoding)
//
// State | meaning
// ------+---------------------------------------------------------------
// DM_PRIO | data port wins contention; fetch denials are being counted
// IM_PRIO | fetch owed a slot; next fetch request wins, even if stale
// -----------------------------------------------------------------------------
module arb_starve_cnt
    import proc_pkg::*;
#(
    parameter int MAX_I_WAIT = ARB_MAX_I_WAIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic gnt_i,
    output logic prio_o
);

    localparam logic [ARB_I_WAIT_W-1:0] MAX_W = ARB_I_WAIT_W'(MAX_I_WAIT);

    logic [ARB_I_WAIT_W-1:0] i_wait_q;
    logic [ARB_I_WAIT_W-1:0] i_wait_d;
    arb_prio_t               prio_q;
    arb_prio_t               prio_d;

    always_comb begin
        i_wait_d = '0;
        prio_d   = prio_q;

        // Only an unbroken run of denials counts; a grant or a dropped
        // request restarts the run.
        if (req_i && !gnt_i) begin
            if (i_wait_q == MAX_W) begin
                i_wait_d = i_wait_q;
            end else begin
                i_wait_d = i_wait_q + {{(ARB_I_WAIT_W-1){1'b0}}, 1'b1};
            end
        end

        // Looking at the next count lets fetch win on the very cycle after
        // its MAX_I_WAIT-th denial.
        case (prio_q)
            DM_PRIO: begin
                if (i_wait_d == MAX_W) begin
                    prio_d = IM_PRIO;
                end
            end
            IM_PRIO: begin
                if (gnt_i) begin
                    prio_d = DM_PRIO;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_wait_q <= '0;
            prio_q   <= DM_PRIO;
        end else begin
            i_wait_q <= i_wait_d;
            prio_q   <= prio_d;
        end
    end

    assign prio_o = prio_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous single-ported RAM between the core's instruction
// fetch port (im_*) and data port (dm_*). At most one access is granted per
// cycle; data beats fetch unless fetch has been starved, in which case fetch
// is owed the next slot. Read data returns one cycle after grant and is
// steered to the requester that issued the read. Writes complete at grant.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   im_req_i, im_addr_i    fetch request / byte address
//   im_gnt_o               fetch accepted this cycle
//   im_rvalid_o, im_rdata_o fetch data return (rdata is 0 when not valid)
//   dm_req_i, dm_we_i,     data request, byte enables (0 = read),
//   dm_addr_i, dm_wdata_i  byte address and store data
//   dm_gnt_o               data access accepted this cycle
//   dm_rvalid_o, dm_rdata_o load data return (rdata is 0 when not valid)
//   mem_en_o, mem_we_o,    RAM strobe, byte enables,
//   mem_addr_o, mem_wdata_o word address and write data
//   mem_rdata_i            RAM read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_I_WAIT = ARB_MAX_I_WAIT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                im_req_i,
    input  logic [ADDR_W-1:0]   im_addr_i,
    output logic                im_gnt_o,
    output logic                im_rvalid_o,
    output logic [DATA_W-1:0]   im_rdata_o,

    input  logic                dm_req_i,
    input  logic [DATA_W/8-1:0] dm_we_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,

    output logic                mem_en_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [ADDR_W-3:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    logic      prio;
    logic      im_win;
    logic      dm_win;
    arb_resp_t resp_own_q;
    arb_resp_t resp_own_d;

    // Byte offsets never reach the RAM; alignment is the requester's job.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{im_addr_i[1:0], dm_addr_i[1:0]};

    arb_starve_cnt #(
        .MAX_I_WAIT (MAX_I_WAIT)
    ) u_starve (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (im_req_i),
        .gnt_i  (im_gnt_o),
        .prio_o (prio)
    );

    // Grant and RAM drive. Grants are held off during reset so nothing
    // reaches the RAM while the arbiter state is being cleared.
    always_comb begin
        im_win      = im_req_i && (!dm_req_i || (prio == IM_PRIO));
        dm_win      = dm_req_i && !im_win;

        im_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        if (!rst_i) begin
            if (im_win) begin
                im_gnt_o   = 1'b1;
                mem_en_o   = 1'b1;
                mem_addr_o = im_addr_i[ADDR_W-1:2];
            end else if (dm_win) begin
                dm_gnt_o    = 1'b1;
                mem_en_o    = 1'b1;
                mem_we_o    = dm_we_i;
                mem_addr_o  = dm_addr_i[ADDR_W-1:2];
                mem_wdata_o = dm_wdata_i;
            end
        end
    end

    // Remember who owns next cycle's RAM read data. Stores return nothing.
    always_comb begin
        resp_own_d = RESP_NONE;
        if (im_gnt_o) begin
            resp_own_d = RESP_IM;
        end else if (dm_gnt_o && (dm_we_i == '0)) begin
            resp_own_d = RESP_DM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_own_q <= RESP_NONE;
        end else begin
            resp_own_q <= resp_own_d;
        end
    end

    // Each requester sees zeros unless the returning word is its own.
    always_comb begin
        im_rvalid_o = (resp_own_q == RESP_IM);
        dm_rvalid_o = (resp_own_q == RESP_DM);
        im_rdata_o  = im_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    end

endmodule
